// File: rtl/sha_work_scheduler_pkg.sv
// Shared types and constants for the SHA work scheduler and its pipeline neighbours.
// HashState carries the eight 32-bit midstate words; Kfunction returns the SHA-256 round constant.
package sha_work_scheduler_pkg;

  typedef logic [7:0][31:0] HashState;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } sched_state_t;

  localparam logic [31:0] SHA_NONCE_COUNT_DEFAULT = 32'd1024;
  localparam int          SHA_PIPE_DEPTH_DEFAULT  = 80;

  // Listed k0..k63 left to right, so k0 lands in the top slot of the packed table.
  localparam logic [63:0][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] Kfunction(input logic [5:0] idx);
    return K_TABLE[6'd63 - idx];
  endfunction

endpackage

// File: rtl/sha_work_scheduler_if.sv
// Work-unit handshake between the host-side work queue (master) and the scheduler (slave).
interface sha_work_scheduler_if;

  logic                               work_valid;
  logic                               work_ready;
  sha_work_scheduler_pkg::HashState   work_state;
  logic [31:0]                        work_w1;
  logic [31:0]                        work_w2;
  logic [31:0]                        work_w3;

  modport master (
    output work_valid, work_state, work_w1, work_w2, work_w3,
    input  work_ready
  );

  modport slave (
    input  work_valid, work_state, work_w1, work_w2, work_w3,
    output work_ready
  );

endinterface

// File: rtl/sha_return_tracker.sv
// Follows candidates leaving the pipeline tail: offset counter, last hit offset, saturating hit count.
module sha_return_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        ret_newblock_i,
  input  logic        ret_valid_i,
  input  logic        hit_i,
  output logic [7:0]  hit_count,
  output logic [31:0] hit_nonce
);

  logic [31:0] r_q, r_d, r_cur;
  logic [31:0] hit_nonce_q, hit_nonce_d;
  logic [7:0]  hit_count_q, hit_count_d;

  // The newblock candidate is offset 0 in its own cycle, so the hit offset uses the loaded value.
  always_comb begin
    r_cur       = ret_newblock_i ? 32'd0 : r_q;
    r_d         = r_cur + 32'd1;
    hit_nonce_d = hit_nonce_q;
    hit_count_d = hit_count_q;
    if (clear) begin
      hit_nonce_d = 32'd0;
      hit_count_d = 8'd0;
    end else if (hit_i && ret_valid_i) begin
      hit_nonce_d = r_cur;
      if (hit_count_q != 8'hff) begin
        hit_count_d = hit_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q         <= 32'd0;
      hit_nonce_q <= 32'd0;
      hit_count_q <= 8'd0;
    end else begin
      r_q         <= r_d;
      hit_nonce_q <= hit_nonce_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
  assign hit_nonce = hit_nonce_q;

endmodule

// File: rtl/sha_work_scheduler.sv
// Sequences one work unit through the SHA pre-pipeline: gap-free nonce sweep, drain, done pulse.
// Defining SHA_SCHED_EARLY_STOP_EN makes a qualified hit during the sweep end it like an abort.
module sha_work_scheduler
  import sha_work_scheduler_pkg::*;
#(
  parameter logic [31:0] NONCE_COUNT = SHA_NONCE_COUNT_DEFAULT,
  parameter int          PIPE_DEPTH  = SHA_PIPE_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  sha_work_scheduler_if.slave         work,
  input  logic                        abort,
  output logic                        pipe_valid_o,
  output logic                        pipe_newblock_o,
  output HashState                    pipe_state_o,
  output logic [31:0]                 pipe_w1_o,
  output logic [31:0]                 pipe_w2_o,
  output logic [31:0]                 pipe_w3_o,
  input  logic                        ret_newblock_i,
  input  logic                        ret_valid_i,
  input  logic                        hit_i,
  output logic                        busy,
  output logic                        sweep_done,
  output logic                        aborted,
  output logic [7:0]                  hit_count,
  output logic [31:0]                 hit_nonce
);

  localparam logic [31:0] LAST_NONCE = NONCE_COUNT - 32'd1;
  localparam logic [31:0] LAST_DRAIN = 32'(PIPE_DEPTH - 1);

  if (NONCE_COUNT == 32'd0) begin : g_bad_nonce_count
    $error("sha_work_scheduler: NONCE_COUNT must be nonzero");
  end

  sched_state_t state_q, state_d;
  logic [31:0]  k_q, k_d;
  logic [31:0]  drain_q, drain_d;
  logic         aborted_q, aborted_d;
  HashState     lat_state_q, lat_state_d;
  logic [31:0]  w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic         accept;
  logic         early_hit;

`ifdef SHA_SCHED_EARLY_STOP_EN
  assign early_hit = hit_i & ret_valid_i;
`else
  assign early_hit = 1'b0;
`endif

  assign accept = (state_q == IDLE) && work.work_valid;

  // Next-state logic; a stop request still lets the current SWEEP cycle issue its candidate.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_d     = drain_q;
    aborted_d   = aborted_q;
    lat_state_d = lat_state_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    w3_d        = w3_q;
    unique case (state_q)
      IDLE: begin
        if (work.work_valid) begin
          lat_state_d = work.work_state;
          w1_d        = work.work_w1;
          w2_d        = work.work_w2;
          w3_d        = work.work_w3;
          k_d         = 32'd0;
          aborted_d   = 1'b0;
          state_d     = SWEEP;
        end
      end
      SWEEP: begin
        k_d = k_q + 32'd1;
        if (abort) begin
          aborted_d = 1'b1;
        end
        if ((k_q == LAST_NONCE) || abort || early_hit) begin
          drain_d = 32'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 32'd1;
        if (drain_q == LAST_DRAIN) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= 32'd0;
      drain_q     <= 32'd0;
      aborted_q   <= 1'b0;
      lat_state_q <= '0;
      w1_q        <= 32'd0;
      w2_q        <= 32'd0;
      w3_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      aborted_q   <= aborted_d;
      lat_state_q <= lat_state_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      w3_q        <= w3_d;
    end
  end

  assign work.work_ready  = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign pipe_valid_o     = (state_q == SWEEP);
  assign pipe_newblock_o  = (state_q == SWEEP) && (k_q == 32'd0);
  assign pipe_state_o     = lat_state_q;
  assign pipe_w1_o        = w1_q;
  assign pipe_w2_o        = w2_q;
  assign pipe_w3_o        = w3_q;
  assign sweep_done       = (state_q == DONE);
  assign aborted          = (state_q == DONE) && aborted_q;

  sha_return_tracker u_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear          (accept),
    .ret_newblock_i (ret_newblock_i),
    .ret_valid_i    (ret_valid_i),
    .hit_i          (hit_i),
    .hit_count      (hit_count),
    .hit_nonce      (hit_nonce)
  );

endmodule

// File: tb/tb_sha_work_scheduler.sv
// Bench for sha_work_scheduler: a 4-nonce instance for timing/handshake, a 1024-nonce instance
// fed by an 80-deep loopback pipeline model with randomized hit patterns and work words.
module tb_sha_work_scheduler;
  import sha_work_scheduler_pkg::*;

  localparam int DEPTH   = 80;
  localparam int NONCE_A = 4;
  localparam int NONCE_B = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sha_work_scheduler_if if_a ();
  sha_work_scheduler_if if_b ();

  logic        abort_a, abort_b;
  logic        pipe_valid_a, pipe_valid_b, pipe_newblock_a, pipe_newblock_b;
  HashState    pipe_state_a, pipe_state_b;
  logic [31:0] pipe_w1_a, pipe_w2_a, pipe_w3_a, pipe_w1_b, pipe_w2_b, pipe_w3_b;
  logic        ret_nb_a, ret_valid_a, hit_a, ret_nb_b, ret_valid_b, hit_b;
  logic        busy_a, busy_b, sweep_done_a, sweep_done_b, aborted_a, aborted_b;
  logic [7:0]  hit_count_a, hit_count_b;
  logic [31:0] hit_nonce_a, hit_nonce_b;

  assign ret_nb_a    = 1'b0;
  assign ret_valid_a = 1'b0;
  assign hit_a       = 1'b0;

  sha_work_scheduler #(.NONCE_COUNT(32'd4), .PIPE_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .work(if_a), .abort(abort_a),
    .pipe_valid_o(pipe_valid_a), .pipe_newblock_o(pipe_newblock_a), .pipe_state_o(pipe_state_a),
    .pipe_w1_o(pipe_w1_a), .pipe_w2_o(pipe_w2_a), .pipe_w3_o(pipe_w3_a),
    .ret_newblock_i(ret_nb_a), .ret_valid_i(ret_valid_a), .hit_i(hit_a),
    .busy(busy_a), .sweep_done(sweep_done_a), .aborted(aborted_a),
    .hit_count(hit_count_a), .hit_nonce(hit_nonce_a)
  );

  sha_work_scheduler #(.NONCE_COUNT(32'd1024), .PIPE_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .work(if_b), .abort(abort_b),
    .pipe_valid_o(pipe_valid_b), .pipe_newblock_o(pipe_newblock_b), .pipe_state_o(pipe_state_b),
    .pipe_w1_o(pipe_w1_b), .pipe_w2_o(pipe_w2_b), .pipe_w3_o(pipe_w3_b),
    .ret_newblock_i(ret_nb_b), .ret_valid_i(ret_valid_b), .hit_i(hit_b),
    .busy(busy_b), .sweep_done(sweep_done_b), .aborted(aborted_b),
    .hit_count(hit_count_b), .hit_nonce(hit_nonce_b)
  );

  // Loopback pipeline model: each issued candidate reappears DEPTH cycles later with its offset.
  bit hit_mask [NONCE_B];
  bit junk_hits = 1'b0;
  bit v_line   [DEPTH];
  bit nb_line  [DEPTH];
  int idx_line [DEPTH];
  int issue_cnt = 0;

  always @(posedge clk) begin
    int idx;
    idx = pipe_newblock_b ? 0 : issue_cnt;
    if (pipe_valid_b) issue_cnt <= idx + 1;
    for (int j = DEPTH - 1; j > 0; j--) begin
      v_line[j]   <= v_line[j-1];
      nb_line[j]  <= nb_line[j-1];
      idx_line[j] <= idx_line[j-1];
    end
    v_line[0]   <= pipe_valid_b;
    nb_line[0]  <= pipe_valid_b && pipe_newblock_b;
    idx_line[0] <= idx;
  end

  assign ret_valid_b = v_line[DEPTH-1];
  assign ret_nb_b    = nb_line[DEPTH-1];
  assign hit_b       = ret_valid_b ? hit_mask[idx_line[DEPTH-1] % NONCE_B] : junk_hits;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearMask();
    for (int j = 0; j < NONCE_B; j++) hit_mask[j] = 1'b0;
  endtask

  // Reference: how many candidates go out, and what the tracker should hold at sweep_done.
  task automatic expectUnit(input int abort_at, output int issued, output int exp_count,
                            output int exp_nonce, output bit exp_aborted);
    issued      = NONCE_B;
    exp_aborted = 1'b0;
    if (abort_at > 0 && abort_at <= NONCE_B) begin
      issued      = abort_at;
      exp_aborted = 1'b1;
    end
`ifdef SHA_SCHED_EARLY_STOP_EN
    for (int h = 0; h < NONCE_B; h++) begin
      if (hit_mask[h]) begin
        if (h + DEPTH + 1 < issued) begin
          issued      = h + DEPTH + 1;
          exp_aborted = 1'b0;
        end
        break;
      end
    end
`endif
    exp_count = 0;
    exp_nonce = 0;
    for (int h = 0; h < issued; h++) begin
      if (hit_mask[h]) begin
        if (exp_count < 255) exp_count++;
        exp_nonce = h;
      end
    end
  endtask

  // Offers one random unit to dut_b (with an ignored IDLE abort) and records what it does.
  task automatic applyStimulus(input string name, input int abort_at, input int drain_abort_at);
    HashState    st;
    logic [31:0] w1, w2, w3, hn_done;
    int n_valid, n_nb, first_nb, done_at, hc_done, data_err, ready_after;
    int issued, exp_count, exp_nonce;
    bit ab_done, exp_aborted;
    for (int j = 0; j < 8; j++) st[j] = $urandom;
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    n_valid = 0; n_nb = 0; first_nb = -1; done_at = -1; hc_done = -1; hn_done = '1;
    data_err = 0; ready_after = 0; ab_done = 1'b0;
    @(negedge clk);
    if_b.work_state = st; if_b.work_w1 = w1; if_b.work_w2 = w2; if_b.work_w3 = w3;
    if_b.work_valid = 1'b1;
    abort_b = 1'b1;
    @(posedge clk);
    #1;
    if_b.work_valid = 1'b0;
    abort_b = 1'b0;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (pipe_valid_b) begin
        n_valid++;
        if (pipe_state_b !== st || pipe_w1_b !== w1 || pipe_w2_b !== w2 || pipe_w3_b !== w3) data_err++;
      end
      if (pipe_newblock_b) begin
        n_nb++;
        if (first_nb < 0) first_nb = i;
      end
      if (done_at >= 0) begin
        ready_after = int'(if_b.work_ready);
        break;
      end
      if (sweep_done_b) begin
        done_at = i;
        ab_done = aborted_b;
        hc_done = int'(hit_count_b);
        hn_done = hit_nonce_b;
      end
      abort_b = (i == abort_at) || (i == drain_abort_at);
    end
    abort_b = 1'b0;
    expectUnit(abort_at, issued, exp_count, exp_nonce, exp_aborted);
    $display("[TB] unit %s: issued %0d, done at cycle %0d", name, n_valid, done_at);
    checkOutput({name, "_valid_count"}, n_valid, issued);
    checkOutput({name, "_newblock_count"}, n_nb, 1);
    checkOutput({name, "_newblock_cycle"}, first_nb, 1);
    checkOutput({name, "_pipe_data"}, data_err, 0);
    checkOutput({name, "_done_cycle"}, done_at, issued + DEPTH + 1);
    checkOutput({name, "_aborted"}, ab_done, exp_aborted);
    checkOutput({name, "_hit_count"}, hc_done, exp_count);
    checkOutput({name, "_hit_nonce"}, hn_done, exp_nonce);
    checkOutput({name, "_ready_after_done"}, ready_after, 1);
  endtask

  initial begin
    HashState    st_a, st_b;
    logic [31:0] w1_a, w1_b;
    int valid_cnt, nb_cnt, nb1, nb2, done_cnt, done1, done2, ready_early, w1_first, w1_second, st_second;
    int hc_pre;
    logic [31:0] hn_pre;

    rst = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0;
    if_a.work_valid = 1'b0; if_a.work_state = '0; if_a.work_w1 = '0; if_a.work_w2 = '0; if_a.work_w3 = '0;
    if_b.work_valid = 1'b0; if_b.work_state = '0; if_b.work_w1 = '0; if_b.work_w2 = '0; if_b.work_w3 = '0;
    clearMask();
    #12;
    checkOutput("rst_ready_a", if_a.work_ready, 1);
    checkOutput("rst_ready_b", if_b.work_ready, 1);
    checkOutput("rst_valid_b", pipe_valid_b, 0);
    checkOutput("rst_newblock_b", pipe_newblock_b, 0);
    checkOutput("rst_state_b", (pipe_state_b == '0), 1);
    checkOutput("rst_w1_b", pipe_w1_b, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOutput("rst_done_b", sweep_done_b, 0);
    checkOutput("rst_aborted_b", aborted_b, 0);
    checkOutput("rst_hit_count_b", hit_count_b, 0);
    checkOutput("rst_hit_nonce_b", hit_nonce_b, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Four-nonce instance: unit A accepted, work_valid held with unit B until it is taken.
    for (int j = 0; j < 8; j++) begin st_a[j] = $urandom; st_b[j] = $urandom; end
    w1_a = $urandom; w1_b = w1_a ^ 32'h5a5a_0001;
    if_a.work_state = st_a; if_a.work_w1 = w1_a; if_a.work_w2 = $urandom; if_a.work_w3 = $urandom;
    if_a.work_valid = 1'b1;
    @(posedge clk);
    #1;
    if_a.work_state = st_b; if_a.work_w1 = w1_b;
    valid_cnt = 0; nb_cnt = 0; nb1 = -1; nb2 = -1; done_cnt = 0; done1 = -1; done2 = -1;
    ready_early = 0; w1_first = 0; w1_second = 0; st_second = 0;
    for (int i = 1; i <= 2 * (NONCE_A + DEPTH + 1) + 4; i++) begin
      @(negedge clk);
      if (pipe_valid_a) valid_cnt++;
      if (pipe_newblock_a) begin
        nb_cnt++;
        if (nb1 < 0) begin nb1 = i; w1_first = int'(pipe_w1_a == w1_a); end
        else begin nb2 = i; w1_second = int'(pipe_w1_a == w1_b); end
      end
      if (nb2 > 0 && i == nb2 + 1) st_second = int'(pipe_state_a == st_b);
      if (sweep_done_a) begin
        done_cnt++;
        if (done1 < 0) done1 = i; else done2 = i;
      end
      if (i <= NONCE_A + DEPTH + 1 && if_a.work_ready) ready_early++;
      if (i == NONCE_A + DEPTH + 3) if_a.work_valid = 1'b0;
    end
    checkOutput("a_valid_count", valid_cnt, 2 * NONCE_A);
    checkOutput("a_newblock_count", nb_cnt, 2);
    checkOutput("a_newblock1_cycle", nb1, 1);
    checkOutput("a_newblock2_cycle", nb2, NONCE_A + DEPTH + 3);
    checkOutput("a_unit1_w1", w1_first, 1);
    checkOutput("a_unit2_w1", w1_second, 1);
    checkOutput("a_unit2_state", st_second, 1);
    checkOutput("a_ready_during_unit", ready_early, 0);
    checkOutput("a_done_count", done_cnt, 2);
    checkOutput("a_done1_cycle", done1, NONCE_A + DEPTH + 1);
    checkOutput("a_done2_cycle", done2, 2 * (NONCE_A + DEPTH + 1) + 1);
    checkOutput("a_ready_final", if_a.work_ready, 1);

    clearMask();
    hit_mask[1] = 1'b1;
    applyStimulus("abort3", 3, 0);

    clearMask();
    hit_mask[5] = 1'b1; hit_mask[700] = 1'b1;
    junk_hits = 1'b1;
    applyStimulus("hits_5_700", 0, NONCE_B + 40);
    junk_hits = 1'b0;

    clearMask();
    for (int j = 0; j < int'($urandom_range(1, 20)); j++) hit_mask[$urandom_range(0, NONCE_B - 1)] = 1'b1;
    applyStimulus("random_hits", 0, 0);

    clearMask();
    for (int j = 100; j < 400; j++) hit_mask[j] = 1'b1;
    applyStimulus("sat_300", 0, 0);

    clearMask();
    hit_mask[10] = 1'b1;
    applyStimulus("hit_10", 0, 0);

    // Reset mid-sweep after some hits have already been counted.
    clearMask();
    for (int j = 0; j <= 50; j++) hit_mask[j] = 1'b1;
    @(negedge clk);
    if_b.work_w1 = $urandom | 32'h1;
    if_b.work_valid = 1'b1;
    @(posedge clk);
    #1;
    if_b.work_valid = 1'b0;
    repeat (DEPTH + 20) @(negedge clk);
    hc_pre = int'(hit_count_b);
    hn_pre = hit_nonce_b;
    checkOutput("pre_rst_hit_count", hc_pre, 19);
    checkOutput("pre_rst_hit_nonce", hn_pre, 18);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", pipe_valid_b, 0);
    checkOutput("midrst_newblock", pipe_newblock_b, 0);
    checkOutput("midrst_w1", pipe_w1_b, 0);
    checkOutput("midrst_busy", busy_b, 0);
    checkOutput("midrst_done", sweep_done_b, 0);
    checkOutput("midrst_hit_count", hit_count_b, 0);
    checkOutput("midrst_hit_nonce", hit_nonce_b, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", if_b.work_ready, 1);
    checkOutput("post_rst_busy", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
